// File: rtl/ifetch_wb_master_if.sv
// Wishbone instruction-bus bundle between the fetch initiator and instruction memory.
interface ifetch_wb_master_if;
  logic [31:0] iaddr_o;
  logic [31:0] idat_o;
  logic        isel_o;
  logic        icyc_o;
  logic        istb_o;
  logic        iwe_o;
  logic [31:0] idat_i;
  logic        iack_i;
  logic        ierr_i;

  modport master (
    output iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o,
    input  idat_i, iack_i, ierr_i
  );

  modport slave (
    input  iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o,
    output idat_i, iack_i, ierr_i
  );
endinterface

// File: rtl/ifetch_wb_master.sv
// Instruction-fetch Wishbone initiator: one outstanding read, valid/ready hand-off
// to decode, redirect squashing, and latched fault on bus error or timeout.
module ifetch_wb_master #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  ifetch_wb_master_if.master         bus,
  input  logic                       redirect_i,
  input  logic [31:0]                target_i,
  output logic [31:0]                instr_o,
  output logic [31:0]                instr_pc_o,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic                       fault_o,
  output logic [31:0]                fault_pc_o
);

  typedef enum logic [1:0] {F_GAP, F_REQ, F_HOLD, F_FAULT} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        cyc_q, cyc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [31:0] tgt;
  logic        timeout;
  logic        resp_end;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    cnt_d      = cnt_q;
    iaddr_d    = iaddr_q;
    cyc_d      = cyc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    tgt        = target_i & ~32'h3;
    timeout    = (cnt_q == TO_LAST);
    resp_end   = bus.iack_i | bus.ierr_i | timeout;

    case (state_q)
      F_GAP: begin
        // Bus stays idle here, so stray acks from the previous cycle are dropped.
        state_d = F_REQ;
        cyc_d   = 1'b1;
        cnt_d   = 8'd0;
        if (redirect_i) begin
          pc_d    = tgt;
          iaddr_d = tgt;
        end else begin
          iaddr_d = pc_q;
        end
      end
      F_REQ: begin
        if (redirect_i) begin
          pc_d = tgt;
          if (resp_end) begin
            cyc_d    = 1'b0;
            squash_d = 1'b0;
            state_d  = F_GAP;
          end else begin
            squash_d = 1'b1;
            cnt_d    = cnt_q + 8'd1;
          end
        end else if (bus.iack_i && !bus.ierr_i) begin
          cyc_d = 1'b0;
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = F_GAP;
          end else begin
            instr_d    = bus.idat_i;
            instr_pc_d = iaddr_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = F_HOLD;
          end
        end else if (bus.ierr_i || timeout) begin
          cyc_d = 1'b0;
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = F_GAP;
          end else begin
            fault_d    = 1'b1;
            fault_pc_d = iaddr_q;
            state_d    = F_FAULT;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      F_HOLD: begin
        // A redirect beats a simultaneous accept: pc+4 is never fetched.
        if (redirect_i) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          state_d = F_GAP;
        end else if (instr_ready_i) begin
          valid_d = 1'b0;
          state_d = F_GAP;
        end
      end
      F_FAULT: begin
        if (redirect_i) begin
          fault_d = 1'b0;
          pc_d    = tgt;
          state_d = F_GAP;
        end
      end
      default: state_d = F_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= F_GAP;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      cnt_q      <= 8'd0;
      iaddr_q    <= RESET_PC;
      cyc_q      <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_q   <= squash_d;
      cnt_q      <= cnt_d;
      iaddr_q    <= iaddr_d;
      cyc_q      <= cyc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.iaddr_o    = iaddr_q;
  assign bus.idat_o     = 32'd0;
  assign bus.isel_o     = cyc_q;
  assign bus.icyc_o     = cyc_q;
  assign bus.istb_o     = cyc_q;
  assign bus.iwe_o      = 1'b0;
  assign instr_o        = instr_q;
  assign instr_pc_o     = instr_pc_q;
  assign instr_valid_o  = valid_q;
  assign fault_o        = fault_q;
  assign fault_pc_o     = fault_pc_q;

endmodule

// File: tb/tb_ifetch_wb_master.sv
// Bench for ifetch_wb_master: directed scenarios plus a transaction-level reference
// model compared against every output on every cycle after the first reset.
module tb_ifetch_wb_master;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = 32'd0;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o, instr_pc_o, fault_pc_o;
  logic        instr_valid_o, fault_o;

  ifetch_wb_master_if bus();

  ifetch_wb_master #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .fault_o       (fault_o),
    .fault_pc_o    (fault_pc_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hfff70713;
      32'h4:   return 32'h0016f793;
      32'h8:   return 32'h0001e2b7;
      32'h14:  return 32'h000900e7;
      default: return a ^ 32'h1357_9bdf;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: decides at negedge+1 what the slave presents for the next edge.
  int          waits = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          never_ack = 1'b0;
  bit          force_ack = 1'b0;
  int          wcnt = 0;

  initial begin
    bus.iack_i = 1'b0;
    bus.ierr_i = 1'b0;
    bus.idat_i = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.icyc_o === 1'b1) begin
        if (!never_ack && wcnt >= waits) begin
          if (bus.iaddr_o == err_addr) begin
            bus.iack_i = 1'b0; bus.ierr_i = 1'b1; bus.idat_i = 32'd0;
          end else begin
            bus.iack_i = 1'b1; bus.ierr_i = 1'b0; bus.idat_i = mem_word(bus.iaddr_o);
          end
        end else begin
          bus.iack_i = 1'b0; bus.ierr_i = 1'b0; bus.idat_i = 32'hDEAD_BEEF;
        end
        wcnt++;
      end else begin
        wcnt = 0;
        bus.iack_i = force_ack;
        bus.ierr_i = 1'b0;
        bus.idat_i = 32'hBAD0_BAD0;
      end
    end
  end

  // Reference model: expected outputs derived from the rules at each edge.
  logic        m_cyc, m_valid, m_fault, m_squash;
  logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_fpc;
  int          m_cnt;
  bit          armed = 1'b0;

  initial begin
    logic        s_rst, s_ack, s_err, s_red, s_rdy, done;
    logic [31:0] t;
    forever begin
      @(posedge clk);
      s_rst = rst; s_ack = bus.iack_i; s_err = bus.ierr_i;
      s_red = redirect_i; s_rdy = instr_ready_i;
      t = target_i & ~32'h3;
      if (s_rst) begin
        m_cyc = 0; m_valid = 0; m_fault = 0; m_squash = 0;
        m_pc = RESET_PC; m_addr = RESET_PC; m_instr = 0; m_ipc = 0; m_fpc = 0; m_cnt = 0;
        armed = 1'b1;
      end else if (armed) begin
        if (m_cyc) begin
          done = s_ack || s_err || (m_cnt == TIMEOUT - 1);
          if (done) begin
            m_cyc = 0;
            if (s_red) begin m_pc = t; m_squash = 0; end
            else if (m_squash) m_squash = 0;
            else if (s_ack && !s_err) begin
              m_valid = 1; m_instr = mem_word(m_addr); m_ipc = m_addr; m_pc = m_addr + 32'd4;
            end else begin
              m_fault = 1; m_fpc = m_addr;
            end
          end else begin
            m_cnt++;
            if (s_red) begin m_pc = t; m_squash = 1; end
          end
        end else if (m_valid) begin
          if (s_red) begin m_pc = t; m_valid = 0; end
          else if (s_rdy) m_valid = 0;
        end else if (m_fault) begin
          if (s_red) begin m_fault = 0; m_pc = t; end
        end else begin
          if (s_red) m_pc = t;
          m_cyc = 1; m_addr = m_pc; m_cnt = 0;
        end
      end
      #1;
      if (armed) begin
        chk("icyc", {31'd0, bus.icyc_o}, {31'd0, m_cyc});
        chk("istb", {31'd0, bus.istb_o}, {31'd0, m_cyc});
        chk("isel", {31'd0, bus.isel_o}, {31'd0, m_cyc});
        chk("iwe", {31'd0, bus.iwe_o}, 32'd0);
        chk("idat_o", bus.idat_o, 32'd0);
        chk("iaddr", bus.iaddr_o, m_addr);
        chk("valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
        chk("fault", {31'd0, fault_o}, {31'd0, m_fault});
        if (m_valid) begin
          chk("instr", instr_o, m_instr);
          chk("instr_pc", instr_pc_o, m_ipc);
        end
        if (m_fault) chk("fault_pc", fault_pc_o, m_fpc);
      end
    end
  end

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; redirect_i = 1'b0; waits = 0; never_ack = 1'b0;
    err_addr = 32'hFFFF_FFFF; force_ack = 1'b0; instr_ready_i = rdy;
    @(negedge clk);
    chk("rst_icyc", {31'd0, bus.icyc_o}, 32'd0);
    chk("rst_iaddr", bus.iaddr_o, RESET_PC);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_fault", {31'd0, fault_o}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!instr_valid_o && n < 200);
    chk("wait_valid", {31'd0, instr_valid_o}, 32'd1);
  endtask

  task automatic wait_cyc();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.icyc_o && n < 200);
    chk("wait_cyc", {31'd0, bus.icyc_o}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect_i = 1'b1; target_i = t;
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    // 1: back-to-back fetches, zero-wait memory
    do_reset(1'b1);
    wait_valid(n);
    chk("t1_first_lat", n, 2);
    chk("t1_i0", instr_o, 32'hfff70713); chk("t1_pc0", instr_pc_o, 32'h0);
    wait_valid(n);
    chk("t1_space1", n, 3);
    chk("t1_i1", instr_o, 32'h0016f793); chk("t1_pc1", instr_pc_o, 32'h4);
    wait_valid(n);
    chk("t1_space2", n, 3);
    chk("t1_i2", instr_o, 32'h0001e2b7); chk("t1_pc2", instr_pc_o, 32'h8);

    // 2: decode stall
    do_reset(1'b0);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("t2_instr", instr_o, 32'hfff70713);
      chk("t2_icyc", {31'd0, bus.icyc_o}, 32'd0);
    end
    instr_ready_i = 1'b1;
    wait_cyc();
    chk("t2_next_addr", bus.iaddr_o, 32'h4);

    // 3: redirect during a wait-stated request
    do_reset(1'b1);
    wait_valid(n);
    waits = 3;
    wait_cyc();
    chk("t3_addr4", bus.iaddr_o, 32'h4);
    pulse_redirect(32'h14);
    seen = 1'b0; n = 0;
    while (!(bus.icyc_o && bus.iaddr_o != 32'h4) && n < 100) begin
      @(negedge clk); n++;
      if (instr_valid_o) seen = 1'b1;
    end
    chk("t3_squashed", {31'd0, seen}, 32'd0);
    chk("t3_addr14", bus.iaddr_o, 32'h14);
    wait_valid(n);
    chk("t3_instr", instr_o, 32'h000900e7); chk("t3_pc", instr_pc_o, 32'h14);

    // 4: bus error, then recovery by redirect
    do_reset(1'b1);
    err_addr = 32'h8;
    n = 0;
    while (!fault_o && n < 100) begin @(negedge clk); n++; end
    chk("t4_fault", {31'd0, fault_o}, 32'd1);
    chk("t4_fault_pc", fault_pc_o, 32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_idle", {31'd0, bus.icyc_o}, 32'd0);
      chk("t4_novalid", {31'd0, instr_valid_o}, 32'd0);
    end
    pulse_redirect(32'h0);
    chk("t4_fault_clr", {31'd0, fault_o}, 32'd0);
    err_addr = 32'hFFFF_FFFF;
    wait_cyc();
    chk("t4_refetch", bus.iaddr_o, 32'h0);

    // 5: timeout, then PC wrap at the top of the address space
    do_reset(1'b1);
    never_ack = 1'b1;
    wait_cyc();
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (bus.icyc_o) n++; else break;
    end
    chk("t5_req_cycles", n, 16);
    chk("t5_fault", {31'd0, fault_o}, 32'd1);
    chk("t5_fault_pc", fault_pc_o, 32'h0);
    never_ack = 1'b0;
    pulse_redirect(32'hFFFF_FFFF);
    wait_cyc();
    chk("t5_top_addr", bus.iaddr_o, 32'hFFFF_FFFC);
    wait_valid(n);
    chk("t5_top_pc", instr_pc_o, 32'hFFFF_FFFC);
    chk("t5_top_instr", instr_o, 32'hECA8_6423);
    wait_cyc();
    chk("t5_wrap_addr", bus.iaddr_o, 32'h0);

    // 6: reset mid bus cycle, then a stray ack
    do_reset(1'b1);
    waits = 5;
    wait_cyc();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_drop", {31'd0, bus.icyc_o}, 32'd0);
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("t6_icyc", {31'd0, bus.icyc_o}, 32'd1);
    chk("t6_addr", bus.iaddr_o, RESET_PC);
    chk("t6_novalid", {31'd0, instr_valid_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_still_novalid", {31'd0, instr_valid_o}, 32'd0);
    end
    wait_valid(n);
    chk("t6_instr", instr_o, 32'hfff70713);
    chk("t6_pc", instr_pc_o, 32'h0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
